// File: rtl/traffic_pkg.sv
// Shared constants for the traffic controller and lamp driver:
// colour codes, fault codes, driver state encoding and a lamp decoder.
package traffic_pkg;

   // Road colour codes as carried on the hwy/cntry buses
   localparam logic [1:0] COL_RED     = 2'd0;
   localparam logic [1:0] COL_YELLOW  = 2'd1;
   localparam logic [1:0] COL_GREEN   = 2'd2;
   localparam logic [1:0] COL_INVALID = 2'd3;

   // Fault codes reported on fault_code
   localparam logic [1:0] FC_NONE         = 2'd0;
   localparam logic [1:0] FC_CONFLICT     = 2'd1;
   localparam logic [1:0] FC_INVALID      = 2'd2;
   localparam logic [1:0] FC_SHORT_YELLOW = 2'd3;

   // Lamp driver state encoding
   localparam logic [1:0] ST_STARTUP = 2'd0;
   localparam logic [1:0] ST_NORMAL  = 2'd1;
   localparam logic [1:0] ST_FAULT   = 2'd2;

   typedef struct packed {
      logic r;
      logic y;
      logic g;
   } lamp_t;

   // One-hot lamp decode of a colour code; an invalid code lights nothing
   function automatic lamp_t decode_colour(input logic [1:0] code);
      lamp_t l;
      l = '0;
      case (code)
         COL_RED:    l.r = 1'b1;
         COL_YELLOW: l.y = 1'b1;
         COL_GREEN:  l.g = 1'b1;
         default:    l = '0;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_flash_gen.sv
// Flash generator for fault mode: a FLASH_DIV prescaler driving a phase
// toggle. While restart is high the phase is held "on" and the prescaler
// is parked at zero, so every fault entry begins with a full "on" period.
module traffic_flash_gen #(
   parameter int FLASH_DIV = 8
) (
   input  logic clock,
   input  logic clear,
   input  logic restart,
   output logic phase
);

   localparam int CW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

   logic [CW-1:0] div_cnt;

   // Prescaler wraps at FLASH_DIV-1 and toggles the phase on each wrap
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         div_cnt <= '0;
         phase   <= 1'b1;
      end else if (restart) begin
         div_cnt <= '0;
         phase   <= 1'b1;
      end else if (div_cnt == CW'(FLASH_DIV - 1)) begin
         div_cnt <= '0;
         phase   <= ~phase;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_lamp_driver.sv
// Lamp driver and conflict monitor. Decodes the highway and country colour
// codes into registered one-hot lamps, enforces an all-red start-up
// interval, and latches into flashing-yellow safe mode on any unsafe
// sample until an operator acknowledges with safe inputs present.
module traffic_lamp_driver
   import traffic_pkg::*;
#(
   parameter int STARTUP_RED = 4,
   parameter int FLASH_DIV   = 8,
   parameter int MIN_YELLOW  = 1
) (
   input  logic       clock,
   input  logic       clear,
   input  logic [1:0] hwy,
   input  logic [1:0] cntry,
   input  logic       fault_ack,
   output logic       hwy_r,
   output logic       hwy_y,
   output logic       hwy_g,
   output logic       cntry_r,
   output logic       cntry_y,
   output logic       cntry_g,
   output logic       fault,
   output logic [1:0] fault_code
);

   localparam int SW = $clog2(STARTUP_RED + 1);
   localparam int DW = $clog2(MIN_YELLOW + 1);
   localparam logic [SW-1:0] START_LOAD = SW'(STARTUP_RED - 1);
   localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_YELLOW);

   logic [1:0]    state;
   logic [SW-1:0] start_cnt;
   logic [DW-1:0] hwy_dwell;
   logic [DW-1:0] cntry_dwell;
   logic [1:0]    shown_hwy;
   logic [1:0]    shown_cntry;
   logic [1:0]    fault_code_q;

   logic          conflict;
   logic          invalid;
   logic          short_hwy;
   logic          short_cntry;
   logic [1:0]    fault_det;
   logic          exit_ok;
   logic          flash_phase;
   lamp_t         hwy_l;
   lamp_t         cntry_l;

   traffic_flash_gen #(
      .FLASH_DIV(FLASH_DIV)
   ) u_flash (
      .clock  (clock),
      .clear  (clear),
      .restart(state != ST_FAULT),
      .phase  (flash_phase)
   );

   // Unsafe-sample checks in priority order: conflict, invalid, short yellow
   always_comb begin
      conflict    = (hwy != COL_RED) && (cntry != COL_RED);
      invalid     = (hwy == COL_INVALID) || (cntry == COL_INVALID);
      // A non-zero dwell means the previous NORMAL sample was YELLOW
      short_hwy   = (hwy != COL_YELLOW) && (hwy_dwell != '0) && (hwy_dwell < DWELL_MAX);
      short_cntry = (cntry != COL_YELLOW) && (cntry_dwell != '0) && (cntry_dwell < DWELL_MAX);
      fault_det   = FC_NONE;
      if (conflict)
         fault_det = FC_CONFLICT;
      else if (invalid)
         fault_det = FC_INVALID;
      else if (short_hwy || short_cntry)
         fault_det = FC_SHORT_YELLOW;
      exit_ok = fault_ack && !invalid && ((hwy == COL_RED) || (cntry == COL_RED));
   end

   // Driver state machine, start-up timer, displayed codes and fault latch
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state        <= ST_STARTUP;
         start_cnt    <= START_LOAD;
         shown_hwy    <= COL_RED;
         shown_cntry  <= COL_RED;
         fault_code_q <= FC_NONE;
      end else begin
         case (state)
            ST_STARTUP: begin
               // Preload red so the first NORMAL cycle does not show stale codes
               shown_hwy   <= COL_RED;
               shown_cntry <= COL_RED;
               if (start_cnt == '0)
                  state <= ST_NORMAL;
               else
                  start_cnt <= start_cnt - 1'b1;
            end
            ST_NORMAL: begin
               if (fault_det != FC_NONE) begin
                  state        <= ST_FAULT;
                  fault_code_q <= fault_det;
               end else begin
                  shown_hwy   <= hwy;
                  shown_cntry <= cntry;
               end
            end
            ST_FAULT: begin
               if (exit_ok) begin
                  state        <= ST_STARTUP;
                  start_cnt    <= START_LOAD;
                  fault_code_q <= FC_NONE;
               end
            end
            default: begin
               state     <= ST_STARTUP;
               start_cnt <= START_LOAD;
            end
         endcase
      end
   end

   // Yellow dwell counters: count consecutive YELLOW samples, saturating
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         hwy_dwell   <= '0;
         cntry_dwell <= '0;
      end else if (state == ST_NORMAL) begin
         if (hwy != COL_YELLOW)
            hwy_dwell <= '0;
         else if (hwy_dwell != DWELL_MAX)
            hwy_dwell <= hwy_dwell + 1'b1;
         if (cntry != COL_YELLOW)
            cntry_dwell <= '0;
         else if (cntry_dwell != DWELL_MAX)
            cntry_dwell <= cntry_dwell + 1'b1;
      end else begin
         hwy_dwell   <= '0;
         cntry_dwell <= '0;
      end
   end

   // Lamp pattern selected by state: all-red, decoded codes, or flash
   always_comb begin
      hwy_l   = decode_colour(shown_hwy);
      cntry_l = decode_colour(shown_cntry);
      case (state)
         ST_STARTUP: begin
            hwy_l   = '{r: 1'b1, y: 1'b0, g: 1'b0};
            cntry_l = '{r: 1'b1, y: 1'b0, g: 1'b0};
         end
         ST_FAULT: begin
            hwy_l   = '{r: 1'b0, y: flash_phase, g: 1'b0};
            cntry_l = '{r: 1'b0, y: flash_phase, g: 1'b0};
         end
         default: ;
      endcase
   end

   // Output register stage; gives the one-cycle sample-to-lamp latency
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         hwy_r      <= 1'b1;
         hwy_y      <= 1'b0;
         hwy_g      <= 1'b0;
         cntry_r    <= 1'b1;
         cntry_y    <= 1'b0;
         cntry_g    <= 1'b0;
         fault      <= 1'b0;
         fault_code <= FC_NONE;
      end else begin
         hwy_r      <= hwy_l.r;
         hwy_y      <= hwy_l.y;
         hwy_g      <= hwy_l.g;
         cntry_r    <= cntry_l.r;
         cntry_y    <= cntry_l.y;
         cntry_g    <= cntry_l.g;
         fault      <= (state == ST_FAULT);
         fault_code <= fault_code_q;
      end
   end

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Bench for traffic_lamp_driver: directed vector table, a clear-mid-flash
// sequence, and randomized traffic checked against a behavioural model.
module tb_traffic_lamp_driver;

   localparam int SR = 4;
   localparam int FD = 8;
   localparam int MY = 3;

   localparam logic [8:0] RR   = 9'b100_100_0_00;
   localparam logic [8:0] HGCR = 9'b001_100_0_00;
   localparam logic [8:0] HYCR = 9'b010_100_0_00;
   localparam logic [8:0] HRCY = 9'b100_010_0_00;

   logic       clock = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] hwy = 2'd0;
   logic [1:0] cntry = 2'd0;
   logic       fault_ack = 1'b0;
   logic       hwy_r, hwy_y, hwy_g, cntry_r, cntry_y, cntry_g, fault;
   logic [1:0] fault_code;
   logic [8:0] act;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   traffic_lamp_driver #(
      .STARTUP_RED(SR),
      .FLASH_DIV  (FD),
      .MIN_YELLOW (MY)
   ) dut (
      .clock     (clock),
      .clear     (clear),
      .hwy       (hwy),
      .cntry     (cntry),
      .fault_ack (fault_ack),
      .hwy_r     (hwy_r),
      .hwy_y     (hwy_y),
      .hwy_g     (hwy_g),
      .cntry_r   (cntry_r),
      .cntry_y   (cntry_y),
      .cntry_g   (cntry_g),
      .fault     (fault),
      .fault_code(fault_code)
   );

   assign act = {hwy_r, hwy_y, hwy_g, cntry_r, cntry_y, cntry_g, fault, fault_code};

   task automatic check(input string name, input logic [8:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b required %b (r y g | r y g | fault code)", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef enum {M_START, M_RUN, M_FLASH} mmode_t;
   mmode_t     m_mode = M_START;
   int         m_elapsed, m_hrun, m_crun, m_age, m_code;
   logic [1:0] m_fc, m_sh, m_sc;
   logic [8:0] m_exp;

   function automatic logic [2:0] lamps(input logic [1:0] code);
      case (code)
         2'd0:    return 3'b100;
         2'd1:    return 3'b010;
         2'd2:    return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [8:0] m_view();
      logic y;
      case (m_mode)
         M_START: return RR;
         M_RUN:   return {lamps(m_sh), lamps(m_sc), 3'b000};
         default: begin
            y = ((m_age / FD) % 2) == 0;
            return {1'b0, y, 1'b0, 1'b0, y, 1'b0, 1'b1, m_fc};
         end
      endcase
   endfunction

   function automatic int fault_of(input logic [1:0] h, input logic [1:0] c);
      if (h != 0 && c != 0) return 1;
      if (h == 3 || c == 3) return 2;
      if ((h != 1 && m_hrun > 0 && m_hrun < MY) || (c != 1 && m_crun > 0 && m_crun < MY))
         return 3;
      return 0;
   endfunction

   always @(posedge clock or posedge clear) begin
      if (clear) begin
         m_mode = M_START; m_elapsed = 0; m_hrun = 0; m_crun = 0; m_age = 0;
         m_fc = 0; m_sh = 0; m_sc = 0; m_exp = RR;
      end else begin
         m_exp = m_view();
         case (m_mode)
            M_START: begin
               m_elapsed++;
               if (m_elapsed >= SR) begin
                  m_mode = M_RUN; m_sh = 0; m_sc = 0;
               end
            end
            M_RUN: begin
               m_code = fault_of(hwy, cntry);
               if (m_code != 0) begin
                  m_mode = M_FLASH; m_fc = 2'(m_code); m_age = 0; m_hrun = 0; m_crun = 0;
               end else begin
                  m_sh = hwy; m_sc = cntry;
                  m_hrun = (hwy == 1) ? m_hrun + 1 : 0;
                  m_crun = (cntry == 1) ? m_crun + 1 : 0;
               end
            end
            default: begin
               if (fault_ack && hwy != 3 && cntry != 3 && (hwy == 0 || cntry == 0)) begin
                  m_mode = M_START; m_elapsed = 0; m_fc = 0;
               end else begin
                  m_age++;
               end
            end
         endcase
      end
   end

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         rst;
      logic [1:0] h;
      logic [1:0] c;
      logic       a;
      logic [8:0] e;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(input bit r, input int h, input int c, input int a,
                               input logic [8:0] e, input int n = 1);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.rst = r && (k == 0);
         v.h = 2'(h); v.c = 2'(c); v.a = 1'(a); v.e = e;
         vecs.push_back(v);
      end
   endfunction

   function automatic logic [8:0] on(input int fc);
      return {6'b010_010, 1'b1, 2'(fc)};
   endfunction

   function automatic logic [8:0] off(input int fc);
      return {6'b000_000, 1'b1, 2'(fc)};
   endfunction

   task automatic step(input int h, input int c, input int a);
      @(negedge clock);
      hwy = 2'(h); cntry = 2'(c); fault_ack = 1'(a);
      @(posedge clock);
      #1;
   endtask

   int ph, pc;

   initial begin
      // Block A: start-up, conflict flash, ack exit, invalid beats ack, short yellow
      add(1, 2, 0, 0, RR);
      add(0, 2, 0, 0, RR, 4);
      add(0, 2, 0, 0, HGCR);
      add(0, 2, 2, 0, HGCR);
      add(0, 2, 0, 0, on(1), 8);
      add(0, 2, 0, 0, off(1), 8);
      add(0, 2, 0, 0, on(1));
      add(0, 2, 0, 1, on(1));
      add(0, 2, 0, 0, RR, 5);
      add(0, 2, 0, 0, HGCR);
      add(0, 0, 3, 1, HGCR);
      add(0, 1, 1, 1, on(2), 2);
      add(0, 2, 0, 1, on(2));
      add(0, 2, 0, 0, RR, 5);
      add(0, 1, 0, 0, HGCR);
      add(0, 1, 0, 0, HYCR);
      add(0, 0, 0, 0, HYCR);
      add(0, 0, 0, 0, on(3), 2);
      // Block B: yellow held exactly MIN_YELLOW is legal, short country yellow faults
      add(1, 2, 0, 0, RR);
      add(0, 2, 0, 0, RR, 4);
      add(0, 1, 0, 0, HGCR);
      add(0, 1, 0, 0, HYCR, 2);
      add(0, 0, 0, 0, HYCR);
      add(0, 0, 0, 0, RR);
      add(0, 0, 1, 0, RR);
      add(0, 0, 0, 0, HRCY);
      add(0, 0, 0, 0, on(3));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         if (vecs[i].rst) begin
            clear = 1'b1;
            #1 check("reset_value", RR);
            #1 clear = 1'b0;
         end
         hwy = vecs[i].h; cntry = vecs[i].c; fault_ack = vecs[i].a;
         @(posedge clock);
         #1 check($sformatf("vec%0d", i), vecs[i].e);
      end

      // Clear asserted mid-flash returns outputs to reset values without a clock edge
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0);
         check("flash_model", m_exp);
      end
      @(negedge clock);
      #2 clear = 1'b1;
      #1 check("clear_mid_flash", RR);
      #1 clear = 1'b0;

      // Randomized traffic against the reference model
      ph = 0; pc = 0;
      for (int i = 0; i < 800; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 6) begin
            ph = int'($urandom_range(0, 3));
            pc = int'($urandom_range(0, 3));
         end else if (r < 55) begin
            if (ph != 0 && pc != 0) pc = 0;
         end else if ($urandom_range(0, 1) == 0) begin
            ph = int'($urandom_range(0, 2));
            pc = 0;
         end else begin
            ph = 0;
            pc = int'($urandom_range(0, 2));
         end
         if ($urandom_range(0, 149) == 0) begin
            @(negedge clock);
            #2 clear = 1'b1;
            #1 check("rand_clear", RR);
            #1 clear = 1'b0;
         end
         step(ph, pc, ($urandom_range(0, 3) == 0) ? 1 : 0);
         check($sformatf("rand%0d", i), m_exp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
